// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path.
// - DefaultClksPerBit: 12 MHz system clock / 115200 baud; the transmitter uses the same
//   value so both ends agree on the bit period.
// - rx_state_e: receiver FSM state encoding (3 bits).
package uart_rx_pkg;

  localparam int unsigned DefaultClksPerBit = 104;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StStop     = 3'd3,
    StWaitIdle = 3'd4
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Parameters:
//   ResetValue  value both flops take while reset is high
// Ports:
//   clk    in   destination clock
//   reset  in   asynchronous, active-high
//   d      in   asynchronous input
//   q      out  synchronized output (two clk cycles of latency)
module sync_2ff #(
  parameter logic ResetValue = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= ResetValue;
      sync_q <= ResetValue;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a one-entry output buffer.
// Parameters:
//   CLKS_PER_BIT   system clocks per bit (>= 4)
// Ports:
//   CLK            in   system clock
//   reset          in   asynchronous, active-high
//   rx             in   asynchronous serial line, idles high
//   rd_ack         in   consumer pulse: clears data_valid, overrun, framing_error
//   data           out  last good byte received
//   data_valid     out  data holds an unconsumed byte
//   framing_error  out  sticky: a stop bit was sampled low
//   overrun        out  sticky: a good byte was dropped while data_valid was set
//   busy           out  receiver FSM is not idle
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_ack,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLoad = CntW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CntW-1:0] BitLoad  = CntW'(CLKS_PER_BIT - 1);

  logic rx_s;

  sync_2ff #(
    .ResetValue(1'b1)
  ) u_rx_sync (
    .clk  (CLK),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      sr_q, sr_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;

  logic tick;
  logic deliver;
  logic ferr_set;

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    sr_d      = sr_q;
    deliver   = 1'b0;
    ferr_set  = 1'b0;

    case (state_q)
      StIdle: begin
        if (!rx_s) begin
          // Half a bit to land in the middle of the start bit.
          cnt_d   = HalfLoad;
          state_d = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          if (rx_s) begin
            state_d = StIdle;  // glitch, not a start bit
          end else begin
            cnt_d     = BitLoad;
            bit_idx_d = 3'd0;
            state_d   = StData;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StData: begin
        if (tick) begin
          sr_d      = {rx_s, sr_q[7:1]};  // LSB first on the wire
          cnt_d     = BitLoad;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StStop: begin
        if (tick) begin
          if (rx_s) begin
            deliver = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_set = 1'b1;
            state_d  = StWaitIdle;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWaitIdle: begin
        // A held-low line (break) must not be re-read as start bits.
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output buffer: an ack and a completing frame in the same cycle leave the new byte valid.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    if (rd_ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
      ferr_d  = 1'b0;
    end
    if (deliver) begin
      if (!valid_q || rd_ack) begin
        data_d  = sr_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (ferr_set) begin
      ferr_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      sr_q      <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      sr_q      <= sr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data          = data_q;
  assign data_valid    = valid_q;
  assign framing_error = ferr_q;
  assign overrun       = ovr_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios followed by random frames,
// compared against a byte-level model of the receive buffer and its flags.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB         = 104;
  localparam int FrameCycles = 10 * CPB;
  // Clock edges, counted from the first low rx cycle, until a good byte is registered:
  // two synchronizer flops, one cycle to leave idle, half a bit, then nine full bits.
  localparam int DeliverEdge = 3 + (CPB - 1) / 2 + 1 + 9 * CPB;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rd_ack = 1'b0;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_error;
  logic       overrun;
  logic       busy;

  uart_rx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .CLK          (CLK),
    .reset        (reset),
    .rx           (rx),
    .rd_ack       (rd_ack),
    .data         (data),
    .data_valid   (data_valid),
    .framing_error(framing_error),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #41.667 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of what the consumer should see.
  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ovr   = 1'b0;
  logic       m_ferr  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data"}, 32'(data), 32'(m_data));
    check({tag, ".data_valid"}, 32'(data_valid), 32'(m_valid));
    check({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
    check({tag, ".framing_error"}, 32'(framing_error), 32'(m_ferr));
    check({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic model_ack();
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
  endtask

  // One frame as the consumer sees it; ack means rd_ack was high when the frame ended.
  task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit ack);
    if (ack) model_ack();
    if (stop_ok) begin
      if (!m_valid) begin
        m_data  = b;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic ack_pulse();
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    model_ack();
  endtask

  // Drive one 8N1 frame cycle by cycle, then tail_low extra low cycles.
  // ack_at / rst_at (cycle index, -1 = never) place an rd_ack pulse or a 2-cycle reset.
  task automatic send(input logic [7:0] b, input bit stop_bit, input int tail_low,
                      input int ack_at, input int rst_at, output int rise_at);
    logic prev_v;
    rise_at = -1;
    prev_v  = data_valid;
    for (int c = 0; c < FrameCycles + tail_low; c++) begin
      if (c < CPB)             rx = 1'b0;
      else if (c < 9 * CPB)    rx = b[(c / CPB) - 1];
      else if (c < 10 * CPB)   rx = stop_bit;
      else                     rx = 1'b0;
      rd_ack = (c == ack_at);
      reset  = (rst_at >= 0) && (c >= rst_at) && (c < rst_at + 2);
      tick();
      if (rst_at >= 0 && c == rst_at) begin
        check("rst.data", 32'(data), 32'd0);
        check("rst.data_valid", 32'(data_valid), 32'd0);
        check("rst.overrun", 32'(overrun), 32'd0);
        check("rst.framing_error", 32'(framing_error), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
      end
      if (data_valid && !prev_v && rise_at < 0) rise_at = c + 1;
      prev_v = data_valid;
    end
    rx     = 1'b1;
    rd_ack = 1'b0;
    reset  = 1'b0;
  endtask

  initial begin
    int         rise;
    logic [7:0] b;
    int         mode;
    bit         stop_ok;

    // Reset state
    idle(3);
    check_all("reset");
    reset = 1'b0;
    idle(2);
    check_all("post_reset");

    // 1. Basic byte and latency
    send(8'h55, 1'b1, 0, -1, -1, rise);
    model_frame(8'h55, 1'b1, 1'b0);
    check("t1.latency_ok", 32'(rise >= 1 && rise <= 1000), 32'd1);
    check_all("t1");
    ack_pulse();
    check_all("t1.ack");

    // 2. Short low glitch is a false start
    rx = 1'b0;
    idle(30);
    check("t2.busy_during", 32'(busy), 32'd1);
    rx = 1'b1;
    idle(100);
    check_all("t2");

    // 3. Framing error followed by a held-low break, then a good byte
    send(8'hA5, 1'b0, 300, -1, -1, rise);
    model_frame(8'hA5, 1'b0, 1'b0);
    check("t3.busy_break", 32'(busy), 32'd1);
    check("t3.no_valid", 32'(data_valid), 32'd0);
    idle(5);
    check_all("t3.break_end");
    send(8'h3C, 1'b1, 0, -1, -1, rise);
    model_frame(8'h3C, 1'b1, 1'b0);
    check_all("t3.next");
    ack_pulse();
    check_all("t3.ack");

    // 4. Overrun
    send(8'h11, 1'b1, 0, -1, -1, rise);
    model_frame(8'h11, 1'b1, 1'b0);
    check_all("t4.first");
    send(8'h22, 1'b1, 0, -1, -1, rise);
    model_frame(8'h22, 1'b1, 1'b0);
    check_all("t4.overrun");
    ack_pulse();
    check_all("t4.ack");

    // 5. rd_ack in the very cycle the next byte completes
    send(8'h5A, 1'b1, 0, -1, -1, rise);
    model_frame(8'h5A, 1'b1, 1'b0);
    check_all("t5.first");
    send(8'h7E, 1'b1, 0, DeliverEdge - 1, -1, rise);
    model_frame(8'h7E, 1'b1, 1'b1);
    check_all("t5.ack_same_cycle");

    // 6. Reset during bit 4 of 0xFF, then a clean byte
    send(8'hFF, 1'b1, 0, -1, 5 * CPB + 20, rise);
    m_data = 8'h00;
    model_ack();
    idle(2);
    check_all("t6.after_reset");
    send(8'h81, 1'b1, 0, -1, -1, rise);
    model_frame(8'h81, 1'b1, 1'b0);
    check_all("t6.next");

    // Random frames: mixed consumer behaviour and occasional bad stop bits
    for (int k = 0; k < 30; k++) begin
      b       = 8'($urandom);
      mode    = int'($urandom_range(0, 2));
      stop_ok = ($urandom_range(0, 7) != 0);
      if (mode == 0) ack_pulse();
      send(b, stop_ok, 0, (mode == 2) ? DeliverEdge - 1 : -1, -1, rise);
      model_frame(b, stop_ok, mode == 2);
      idle(4);
      check_all($sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
